// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: splits each one-hot L-move into a vertical
// leg and a horizontal leg with fanfare, and muxes them with the UART stream.
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [4:0]  mv_indx,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp,
  output logic        tour_active,
  output logic        tour_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] HOLD_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] HOLD_H = 3'd4;

  localparam logic [4:0] LAST_INDX  = 5'(NUM_MOVES - 1);
  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_FANFARE = 4'h5;
  localparam logic [7:0] HDG_N      = 8'h00;
  localparam logic [7:0] HDG_W      = 8'h3F;
  localparam logic [7:0] HDG_S      = 8'h7F;
  localparam logic [7:0] HDG_E      = 8'hBF;
  localparam logic [7:0] RESP_DONE  = 8'hA5;
  localparam logic [7:0] RESP_BUSY  = 8'h5A;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [4:0]  mv_indx_nxt;
  logic        tour_err_nxt;
  logic        move_legal;
  logic        last_move;
  logic [7:0]  vert_hdg;
  logic [3:0]  vert_sq;
  logic [7:0]  horz_hdg;
  logic [3:0]  horz_sq;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;

  // A zero or multi-hot move is a corrupted solution entry and aborts the tour.
  assign move_legal = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign last_move  = (mv_indx == LAST_INDX);

  always_comb begin
    vert_hdg = HDG_N;
    vert_sq  = 4'd0;
    horz_hdg = HDG_E;
    horz_sq  = 4'd0;
    case (move)
      8'h01: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
      8'h02: begin vert_hdg = HDG_N; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
      8'h04: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
      8'h08: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_W; horz_sq = 4'd2; end
      8'h10: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_W; horz_sq = 4'd1; end
      8'h20: begin vert_hdg = HDG_S; vert_sq = 4'd2; horz_hdg = HDG_E; horz_sq = 4'd1; end
      8'h40: begin vert_hdg = HDG_S; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
      8'h80: begin vert_hdg = HDG_N; vert_sq = 4'd1; horz_hdg = HDG_E; horz_sq = 4'd2; end
      default: begin
        vert_hdg = HDG_N;
        vert_sq  = 4'd0;
        horz_hdg = HDG_E;
        horz_sq  = 4'd0;
      end
    endcase
  end

  assign vert_cmd = {OP_MOVE, vert_hdg, vert_sq};
  assign horz_cmd = {OP_FANFARE, horz_hdg, horz_sq};

  // In VERT/HORZ a consume wins over a completion arriving in the same cycle;
  // the completion has to be presented again once we are in the hold state.
  always_comb begin
    state_nxt    = state;
    mv_indx_nxt  = mv_indx;
    tour_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_tour) begin
          mv_indx_nxt = 5'd0;
          state_nxt   = VERT;
        end
      end
      VERT: begin
        if (!move_legal) begin
          tour_err_nxt = 1'b1;
          state_nxt    = IDLE;
        end else if (clr_cmd_rdy) begin
          state_nxt = HOLD_V;
        end
      end
      HOLD_V: begin
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        if (clr_cmd_rdy) state_nxt = HOLD_H;
      end
      HOLD_H: begin
        if (send_resp) begin
          if (last_move) begin
            state_nxt = IDLE;
          end else begin
            mv_indx_nxt = mv_indx + 5'd1;
            state_nxt   = VERT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mv_indx  <= 5'd0;
      tour_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      mv_indx  <= mv_indx_nxt;
      tour_err <= tour_err_nxt;
    end
  end

  assign tour_active = (state != IDLE);

  // The move memory is addressed by mv_indx, so the decoded legs stay stable
  // through the hold states without needing a separate command register.
  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = 1'b0;
    case (state)
      IDLE:    begin cmd = cmd_UART; cmd_rdy = cmd_rdy_UART; end
      VERT:    begin cmd = vert_cmd; cmd_rdy = 1'b1; end
      HOLD_V:  begin cmd = vert_cmd; cmd_rdy = 1'b0; end
      HORZ:    begin cmd = horz_cmd; cmd_rdy = 1'b1; end
      HOLD_H:  begin cmd = horz_cmd; cmd_rdy = 1'b0; end
      default: begin cmd = cmd_UART; cmd_rdy = 1'b0; end
    endcase
  end

  always_comb begin
    resp = RESP_BUSY;
    if (state == IDLE) begin
      resp = RESP_DONE;
    end else if ((state == HOLD_H) && send_resp && last_move) begin
      resp = RESP_DONE;
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: directed vector tables, hand-written
// corner sequences and randomized full tours against a move-vector model.
module tb_tour_cmd_seq;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;

  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;
  logic        tour_active;
  logic        tour_err;

  logic [4:0]  one_mv_indx;
  logic [15:0] one_cmd;
  logic        one_cmd_rdy;
  logic [7:0]  one_resp;
  logic        one_tour_active;
  logic        one_tour_err;

  logic [7:0]  mem [0:31];

  int total = 0;
  int bad   = 0;

  // Knight displacement (x east, y north) for each one-hot move bit.
  int vdx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int vdy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] vert;
    logic [15:0] horz;
  } leg_vec_t;

  typedef struct {
    logic [15:0] ucmd;
    logic        urdy;
  } idle_vec_t;

  leg_vec_t  legTable [8];
  idle_vec_t idleTable [4];

  tour_cmd_seq #(.NUM_MOVES(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .mv_indx(mv_indx), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp),
    .tour_active(tour_active), .tour_err(tour_err)
  );

  tour_cmd_seq #(.NUM_MOVES(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .mv_indx(one_mv_indx), .cmd(one_cmd), .cmd_rdy(one_cmd_rdy), .resp(one_resp),
    .tour_active(one_tour_active), .tour_err(one_tour_err)
  );

  assign move = mem[mv_indx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] legCmd(input logic [7:0] mv, input bit horizontal);
    int dx;
    int dy;
    int mag;
    logic [7:0] hdg;
    dx = 0;
    dy = 0;
    for (int b = 0; b < 8; b++) begin
      if (mv[b]) begin
        dx = vdx[b];
        dy = vdy[b];
      end
    end
    if (horizontal) begin
      hdg = (dx > 0) ? 8'hBF : 8'h3F;
      mag = (dx < 0) ? -dx : dx;
      return {4'h5, hdg, mag[3:0]};
    end
    hdg = (dy > 0) ? 8'h00 : 8'h7F;
    mag = (dy < 0) ? -dy : dy;
    return {4'h4, hdg, mag[3:0]};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    start_tour   = 1'b0;
    cmd_UART     = 16'h0000;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fillRandomTour();
    for (int i = 0; i < 32; i++) mem[i] = 8'h01 << $urandom_range(7, 0);
  endtask

  task automatic applyStimulus(input logic st, input logic clr, input logic snd);
    start_tour  = st;
    clr_cmd_rdy = clr;
    send_resp   = snd;
    nextCycle();
    start_tour  = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
  endtask

  task automatic completeLeg();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic runRandomTour(input int tourNo);
    logic [15:0] expq [$];
    int   k;
    int   cycles;
    int   n5a;
    bit   consumed;
    bit   sawFinal;
    logic [7:0] expResp;
    fillRandomTour();
    mem[5] = 8'h08;
    for (int i = 0; i < 24; i++) begin
      expq.push_back(legCmd(mem[i], 1'b0));
      expq.push_back(legCmd(mem[i], 1'b1));
    end
    k = 0; cycles = 0; n5a = 0; consumed = 0; sawFinal = 0;
    start_tour = 1'b1;
    while (k < 48 && cycles < 3000) begin
      nextCycle();
      cycles++;
      start_tour   = ($urandom_range(9, 0) == 0);
      cmd_UART     = 16'($urandom);
      cmd_rdy_UART = 1'($urandom);
      if ($urandom_range(7, 0) == 0) begin
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'b1;
      end else if (!consumed) begin
        clr_cmd_rdy = ($urandom_range(2, 0) == 0);
        send_resp   = ($urandom_range(4, 0) == 0);
      end else begin
        send_resp   = ($urandom_range(2, 0) == 0);
        clr_cmd_rdy = ($urandom_range(4, 0) == 0);
      end
      @(negedge clk);
      checkOutput("rnd_active", 32'(tour_active), 32'd1);
      checkOutput("rnd_indx", 32'(mv_indx), 32'(k / 2));
      checkOutput("rnd_rdy", 32'(cmd_rdy), 32'(!consumed));
      if (!consumed || (k % 2 == 0)) checkOutput("rnd_cmd", 32'(cmd), 32'(expq[k]));
      if (!consumed && k == 10) checkOutput("idx5_vert", 32'(cmd), 32'h47F1);
      if (!consumed && k == 11) checkOutput("idx5_horz", 32'(cmd), 32'h53F2);
      expResp = (consumed && send_resp && k == 47) ? 8'hA5 : 8'h5A;
      checkOutput("rnd_resp", 32'(resp), 32'(expResp));
      if (consumed && send_resp) begin
        if (resp == 8'h5A) n5a++;
        if (k == 47) sawFinal = (resp == 8'hA5);
      end
      if (!consumed) begin
        if (clr_cmd_rdy) consumed = 1;
      end else if (send_resp) begin
        consumed = 0;
        k++;
      end
    end
    checkOutput("rnd_budget", 32'(k), 32'd48);
    nextCycle();
    clearInputs();
    cmd_UART = 16'h1234;
    @(negedge clk);
    checkOutput("rnd_end_active", 32'(tour_active), 32'd0);
    checkOutput("rnd_end_indx", 32'(mv_indx), 32'd23);
    checkOutput("rnd_end_resp", 32'(resp), 32'hA5);
    checkOutput("rnd_end_cmd", 32'(cmd), 32'h1234);
    checkOutput("rnd_n5a", 32'(n5a), 32'd47);
    checkOutput("rnd_final", 32'(sawFinal), 32'd1);
    $display("[TB] random tour %0d finished in %0d cycles", tourNo, cycles);
    nextCycle();
  endtask

  initial begin
    legTable[0] = '{8'h01, 16'h4002, 16'h5BF1};
    legTable[1] = '{8'h02, 16'h4002, 16'h53F1};
    legTable[2] = '{8'h04, 16'h4001, 16'h53F2};
    legTable[3] = '{8'h08, 16'h47F1, 16'h53F2};
    legTable[4] = '{8'h10, 16'h47F2, 16'h53F1};
    legTable[5] = '{8'h20, 16'h47F2, 16'h5BF1};
    legTable[6] = '{8'h40, 16'h47F1, 16'h5BF2};
    legTable[7] = '{8'h80, 16'h4001, 16'h5BF2};
    idleTable[0] = '{16'h43F1, 1'b1};
    idleTable[1] = '{16'h1234, 1'b0};
    idleTable[2] = '{16'hFFFF, 1'b1};
    idleTable[3] = '{16'h5BF2, 1'b0};
    for (int i = 0; i < 32; i++) mem[i] = 8'h01;

    // Reset values while rst_n is held low.
    clearInputs();
    rst_n = 1'b0;
    cmd_UART = 16'h43F1;
    cmd_rdy_UART = 1'b1;
    #2;
    checkOutput("rst_indx", 32'(mv_indx), 32'd0);
    checkOutput("rst_active", 32'(tour_active), 32'd0);
    checkOutput("rst_err", 32'(tour_err), 32'd0);
    checkOutput("rst_resp", 32'(resp), 32'hA5);
    checkOutput("rst_cmd", 32'(cmd), 32'h43F1);
    checkOutput("rst_rdy", 32'(cmd_rdy), 32'd1);
    doReset();

    // Idle pass-through table.
    for (int i = 0; i < 4; i++) begin
      cmd_UART = idleTable[i].ucmd;
      cmd_rdy_UART = idleTable[i].urdy;
      @(negedge clk);
      checkOutput("idle_cmd", 32'(cmd), 32'(idleTable[i].ucmd));
      checkOutput("idle_rdy", 32'(cmd_rdy), 32'(idleTable[i].urdy));
      checkOutput("idle_active", 32'(tour_active), 32'd0);
      checkOutput("idle_resp", 32'(resp), 32'hA5);
      nextCycle();
    end

    // Single-move tours for every move bit on the NUM_MOVES=1 instance.
    for (int i = 0; i < 8; i++) begin
      doReset();
      for (int j = 0; j < 32; j++) mem[j] = legTable[i].mv;
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("one_vert", 32'(one_cmd), 32'(legTable[i].vert));
      checkOutput("one_vert_rdy", 32'(one_cmd_rdy), 32'd1);
      checkOutput("one_vert_model", 32'(one_cmd), 32'(legCmd(legTable[i].mv, 1'b0)));
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("one_holdv_rdy", 32'(one_cmd_rdy), 32'd0);
      checkOutput("one_holdv_cmd", 32'(one_cmd), 32'(legTable[i].vert));
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("one_horz", 32'(one_cmd), 32'(legTable[i].horz));
      checkOutput("one_horz_rdy", 32'(one_cmd_rdy), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      send_resp = 1'b1;
      @(negedge clk);
      checkOutput("one_last_resp", 32'(one_resp), 32'hA5);
      checkOutput("one_mid_resp", 32'(resp), 32'h5A);
      nextCycle();
      send_resp = 1'b0;
      @(negedge clk);
      checkOutput("one_idle", 32'(one_tour_active), 32'd0);
      checkOutput("one_idle_indx", 32'(one_mv_indx), 32'd0);
    end

    // Masking in HOLD_V: UART and start_tour must not disturb the tour.
    doReset();
    fillRandomTour();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cmd_rdy_UART = 1'b1;
    cmd_UART = 16'hFFFF;
    start_tour = 1'b1;
    @(negedge clk);
    checkOutput("mask_cmd", 32'(cmd), 32'(legCmd(mem[0], 1'b0)));
    checkOutput("mask_rdy", 32'(cmd_rdy), 32'd0);
    nextCycle();
    start_tour = 1'b0;
    @(negedge clk);
    checkOutput("mask_rdy2", 32'(cmd_rdy), 32'd0);
    checkOutput("mask_indx", 32'(mv_indx), 32'd0);
    checkOutput("mask_active", 32'(tour_active), 32'd1);
    nextCycle();

    // Illegal encoding at index 2 aborts the tour with one tour_err pulse.
    doReset();
    fillRandomTour();
    mem[2] = 8'h03;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) completeLeg();
    @(negedge clk);
    checkOutput("ill_indx", 32'(mv_indx), 32'd2);
    checkOutput("ill_rdy", 32'(cmd_rdy), 32'd1);
    checkOutput("ill_err0", 32'(tour_err), 32'd0);
    nextCycle();
    cmd_rdy_UART = 1'b1;
    cmd_UART = 16'hBEEF;
    @(negedge clk);
    checkOutput("ill_err1", 32'(tour_err), 32'd1);
    checkOutput("ill_active", 32'(tour_active), 32'd0);
    checkOutput("ill_pass_rdy", 32'(cmd_rdy), 32'd1);
    checkOutput("ill_pass_cmd", 32'(cmd), 32'hBEEF);
    nextCycle();
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
    checkOutput("ill_err2", 32'(tour_err), 32'd0);
    checkOutput("ill_pass_rdy2", 32'(cmd_rdy), 32'd0);
    nextCycle();

    // Asynchronous reset in HOLD_H at index 10, then a clean restart.
    doReset();
    fillRandomTour();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) completeLeg();
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ar_indx", 32'(mv_indx), 32'd10);
    checkOutput("ar_hold_rdy", 32'(cmd_rdy), 32'd0);
    cmd_UART = 16'h1357;
    cmd_rdy_UART = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_rst_indx", 32'(mv_indx), 32'd0);
    checkOutput("ar_rst_active", 32'(tour_active), 32'd0);
    checkOutput("ar_rst_cmd", 32'(cmd), 32'h1357);
    checkOutput("ar_rst_rdy", 32'(cmd_rdy), 32'd1);
    checkOutput("ar_rst_resp", 32'(resp), 32'hA5);
    nextCycle();
    rst_n = 1'b1;
    clearInputs();
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ar_restart_indx", 32'(mv_indx), 32'd0);
    checkOutput("ar_restart_rdy", 32'(cmd_rdy), 32'd1);
    checkOutput("ar_restart_cmd", 32'(cmd), 32'(legCmd(mem[0], 1'b0)));
    nextCycle();

    // Randomized full tours with stray handshakes and UART noise.
    for (int t = 0; t < 3; t++) begin
      doReset();
      runRandomTour(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
